// File: rtl/wide_add_pkg.sv
// rtl/wide_add_pkg.sv - shared types and defaults for the wide_add_seq sequential adder
`timescale 1ns/1ps
package wide_add_pkg;

   localparam int SLICE_W_DEF = 16;
   localparam int NSLICE_DEF  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // A single-slice build still needs a 1-bit index register.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cla_slice.sv
// rtl/cla_slice.sv - combinational SLICE_W-bit carry-lookahead adder from 4-bit G/P groups
`timescale 1ns/1ps
module cla_slice #(
   parameter int SLICE_W = 16
) (
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               cin,
   output logic [SLICE_W-1:0] sum,
   output logic               cout,
   output logic               cmsb
);

   localparam int NG = SLICE_W / 4;

   logic [SLICE_W-1:0] g;
   logic [SLICE_W-1:0] p;
   logic [SLICE_W:0]   c;

   assign g = a & b;
   assign p = a ^ b;

   // Carries inside a group are fully expanded; group carries chain via group G/P.
   always_comb begin
      c    = '0;
      c[0] = cin;
      for (int k = 0; k < NG; k++) begin
         logic [3:0] g4;
         logic [3:0] p4;
         logic       c0;
         g4 = g[4*k +: 4];
         p4 = p[4*k +: 4];
         c0 = c[4*k];
         c[4*k+1] = g4[0] | (p4[0] & c0);
         c[4*k+2] = g4[1] | (p4[1] & g4[0]) | (&p4[1:0] & c0);
         c[4*k+3] = g4[2] | (p4[2] & g4[1]) | (&p4[2:1] & g4[0]) | (&p4[2:0] & c0);
         c[4*k+4] = (g4[3] | (p4[3] & g4[2]) | (&p4[3:2] & g4[1]) | (&p4[3:1] & g4[0]))
                  | (&p4 & c0);
      end
   end

   assign sum  = p ^ c[SLICE_W-1:0];
   assign cout = c[SLICE_W];
   assign cmsb = c[SLICE_W-1];

endmodule

// File: rtl/wide_add_seq.sv
// rtl/wide_add_seq.sv - multi-cycle wide adder, one shared CLA slice per cycle; WIDE_ADD_SUB_EN adds subtract
`timescale 1ns/1ps
module wide_add_seq
   import wide_add_pkg::*;
#(
   parameter int SLICE_W = SLICE_W_DEF,
   parameter int NSLICE  = NSLICE_DEF,
   localparam int WIDTH  = SLICE_W * NSLICE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef WIDE_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int IW = idx_width(NSLICE);

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   a_q, b_q;
   logic               carry_q;
   logic [IW-1:0]      idx;
   logic               last;
   logic [WIDTH-1:0]   b_eff;
   logic               cin_eff;
   logic [SLICE_W-1:0] sa, sb, ss;
   logic               sc, smsb;

`ifdef WIDE_ADD_SUB_EN
   assign b_eff   = sub ? ~b : b;
   assign cin_eff = sub | cin;
`else
   assign b_eff   = b;
   assign cin_eff = cin;
`endif

   assign last = (idx == IW'(NSLICE - 1));
   assign sa   = a_q[idx*SLICE_W +: SLICE_W];
   assign sb   = b_q[idx*SLICE_W +: SLICE_W];

   cla_slice #(.SLICE_W(SLICE_W)) u_slice (
      .a    (sa),
      .b    (sb),
      .cin  (carry_q),
      .sum  (ss),
      .cout (sc),
      .cmsb (smsb)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // in_ready decodes registered state only; rst masks it while reset is held.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = ~rst;
            if (in_valid) state_nxt = RUN;
         end
         RUN: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx     <= '0;
         sum     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= b_eff;
                  carry_q <= cin_eff;
                  idx     <= '0;
               end
            end
            RUN: begin
               sum[idx*SLICE_W +: SLICE_W] <= ss;
               carry_q <= sc;
               if (last) begin
                  cout <= sc;
                  ovf  <= sc ^ smsb;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
